// File: rtl/rx_line_framer_if.sv
// Byte stream carrying a completed line from the framer to the encrypter/transmit path.
interface rx_line_framer_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       trunc;
    logic       ready;

    modport master (
        output valid,
        output data,
        output last,
        output trunc,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        input  trunc,
        output ready
    );
endinterface

// File: rtl/rx_line_framer.sv
// Collects received bytes into a line buffer until TERM_LEN consecutive
// TERM_BYTEs arrive (or the buffer fills), then streams the line out.
// Input arriving while a line drains is dropped and counted.
module rx_line_framer #(
    parameter int         DEPTH_LG  = 10,
    parameter logic [7:0] TERM_BYTE = 8'h31,
    parameter int         TERM_LEN  = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [7:0]        i_data,
    input  logic              i_break,
    input  logic              i_perr,
    input  logic              i_ferr,
    rx_line_framer_if.master  out_if,
    output logic              o_busy,
    output logic [15:0]       o_drop_cnt,
    output logic [7:0]        o_err_cnt
);
    localparam int                DEPTH      = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] ZERO_P     = (DEPTH_LG + 1)'(0);
    localparam logic [DEPTH_LG:0] ONE_P      = (DEPTH_LG + 1)'(1);
    localparam logic [DEPTH_LG:0] LAST_SLOT  = (DEPTH_LG + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LG:0] FULL_LEN   = (DEPTH_LG + 1)'(DEPTH);
    localparam logic [DEPTH_LG:0] TERM_LEN_P = (DEPTH_LG + 1)'(TERM_LEN);
    localparam logic [2:0]        TERM_LEN_3 = 3'(TERM_LEN);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [7:0]        mem_r [DEPTH];
    logic [DEPTH_LG:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [DEPTH_LG:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [DEPTH_LG:0] line_len_r, line_len_nxt_s;
    logic [DEPTH_LG:0] term_len_s;
    logic [2:0]        match_r, match_nxt_s, match_inc_s;
    logic              valid_r, valid_nxt_s;
    logic              last_r, last_nxt_s;
    logic              trunc_r, trunc_nxt_s;
    logic              busy_r;
    logic [7:0]        data_r;
    logic [15:0]       drop_cnt_r, drop_cnt_nxt_s;
    logic [7:0]        err_cnt_r, err_cnt_nxt_s;
    logic              any_err_s, good_s, err_s, xfer_s, load_s, wr_en_s;

    assign any_err_s   = i_break | i_perr | i_ferr;
    assign good_s      = i_stb & ~any_err_s;
    assign err_s       = i_stb & any_err_s;
    assign xfer_s      = valid_r & out_if.ready;
    // The output slot refills whenever it is empty or being consumed, so the
    // read pointer runs one byte ahead and i_ready=1 gives one byte per cycle.
    assign load_s      = (state_r == ST_DRAIN) && (rd_ptr_r != line_len_r) &&
                         (!valid_r || out_if.ready);
    assign match_inc_s = (i_data == TERM_BYTE) ? (match_r + 3'd1) : 3'd0;
    // Payload length if this byte completes the terminator (terminators not emitted).
    assign term_len_s  = wr_ptr_r + ONE_P - TERM_LEN_P;
    assign wr_en_s     = !i_reset && (state_r == ST_FILL) && good_s;

    // Next-state, pointer, flag and counter computation.
    always_comb begin
        state_nxt_s    = state_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        line_len_nxt_s = line_len_r;
        match_nxt_s    = match_r;
        valid_nxt_s    = valid_r;
        last_nxt_s     = last_r;
        trunc_nxt_s    = trunc_r;
        drop_cnt_nxt_s = drop_cnt_r;
        err_cnt_nxt_s  = err_cnt_r;
        case (state_r)
            ST_FILL: begin
                if (good_s) begin
                    wr_ptr_nxt_s = wr_ptr_r + ONE_P;
                    match_nxt_s  = match_inc_s;
                    if (match_inc_s == TERM_LEN_3) begin
                        if (term_len_s == ZERO_P) begin
                            // Bare terminator: nothing to send, restart the line.
                            wr_ptr_nxt_s = ZERO_P;
                            match_nxt_s  = 3'd0;
                        end else begin
                            state_nxt_s    = ST_DRAIN;
                            line_len_nxt_s = term_len_s;
                            trunc_nxt_s    = 1'b0;
                        end
                    end else if (wr_ptr_r == LAST_SLOT) begin
                        // Buffer full: any partial terminator is sent as payload.
                        state_nxt_s    = ST_DRAIN;
                        line_len_nxt_s = FULL_LEN;
                        trunc_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else if (err_s) begin
                    err_cnt_nxt_s = (err_cnt_r == 8'hFF) ? err_cnt_r : (err_cnt_r + 8'd1);
                    match_nxt_s   = 3'd0;
                end else begin
                    match_nxt_s = match_r;
                end
            end
            ST_DRAIN: begin
                if (i_stb) begin
                    drop_cnt_nxt_s = (drop_cnt_r == 16'hFFFF) ? drop_cnt_r : (drop_cnt_r + 16'd1);
                end else begin
                    drop_cnt_nxt_s = drop_cnt_r;
                end
                if (load_s) begin
                    rd_ptr_nxt_s = rd_ptr_r + ONE_P;
                    valid_nxt_s  = 1'b1;
                    last_nxt_s   = (rd_ptr_r == (line_len_r - ONE_P));
                end else if (xfer_s && last_r) begin
                    state_nxt_s  = ST_FILL;
                    wr_ptr_nxt_s = ZERO_P;
                    rd_ptr_nxt_s = ZERO_P;
                    match_nxt_s  = 3'd0;
                    valid_nxt_s  = 1'b0;
                    last_nxt_s   = 1'b0;
                    trunc_nxt_s  = 1'b0;
                end else if (xfer_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State and control registers; reset wins over everything else.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_FILL;
            wr_ptr_r   <= ZERO_P;
            rd_ptr_r   <= ZERO_P;
            line_len_r <= ZERO_P;
            match_r    <= 3'd0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            trunc_r    <= 1'b0;
            busy_r     <= 1'b0;
            drop_cnt_r <= 16'd0;
            err_cnt_r  <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            line_len_r <= line_len_nxt_s;
            match_r    <= match_nxt_s;
            valid_r    <= valid_nxt_s;
            last_r     <= last_nxt_s;
            trunc_r    <= trunc_nxt_s;
            busy_r     <= (state_nxt_s == ST_DRAIN);
            drop_cnt_r <= drop_cnt_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
        end
    end

    // Line buffer write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[DEPTH_LG-1:0]] <= i_data;
        end
    end

    // Registered read port feeding the output data slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_r <= 8'd0;
        end else if (load_s) begin
            data_r <= mem_r[rd_ptr_r[DEPTH_LG-1:0]];
        end else begin
            data_r <= data_r;
        end
    end

    assign out_if.valid = valid_r;
    assign out_if.data  = data_r;
    assign out_if.last  = last_r;
    assign out_if.trunc = trunc_r;
    assign o_busy       = busy_r;
    assign o_drop_cnt   = drop_cnt_r;
    assign o_err_cnt    = err_cnt_r;
endmodule

// File: tb/tb_rx_line_framer.sv
// Self-checking bench for rx_line_framer: directed cases with literal
// expectations plus randomized traffic checked each cycle against a
// queue-based line model.
module tb_rx_line_framer;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TLEN  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stb, brk, perr, ferr, rdy;
    logic [7:0]  din;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [7:0]  err_cnt;

    rx_line_framer_if bus ();
    assign bus.ready = rdy;

    rx_line_framer #(.DEPTH_LG(DL), .TERM_BYTE(8'h31), .TERM_LEN(TLEN)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_stb      (stb),
        .i_data     (din),
        .i_break    (brk),
        .i_perr     (perr),
        .i_ferr     (ferr),
        .out_if     (bus),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt),
        .o_err_cnt  (err_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // behavioural model
    logic [7:0] line_q[$];
    logic [7:0] out_q[$];
    int  m_match = 0;
    bit  m_drain = 1'b0;
    bit  m_trunc = 1'b0;
    int  m_age = 0;
    int  m_drop = 0;
    int  m_err = 0;

    // observation
    logic [9:0] log_q[$];
    bit  cmp_en = 1'b0;
    bit  busy_seen = 1'b0;
    logic prev_valid = 1'b0;
    int  first_valid_cyc = 0;
    int  last_stb_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: advances one clock using the inputs the bench is driving.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                line_q.delete();
                out_q.delete();
                m_match = 0;
                m_drain = 1'b0;
                m_trunc = 1'b0;
                m_age   = 0;
                m_drop  = 0;
                m_err   = 0;
            end else if (m_drain) begin
                if (stb) m_drop = (m_drop == 65535) ? 65535 : m_drop + 1;
                if (m_age >= 1 && rdy) begin
                    void'(out_q.pop_front());
                    if (out_q.size() == 0) begin
                        m_drain = 1'b0;
                        m_trunc = 1'b0;
                        m_match = 0;
                    end
                end
                m_age++;
            end else if (stb && !(brk || perr || ferr)) begin
                line_q.push_back(din);
                m_match = (din == 8'h31) ? m_match + 1 : 0;
                if (m_match == TLEN) begin
                    int len;
                    len = line_q.size() - TLEN;
                    if (len > 0) begin
                        for (int i = 0; i < len; i++) out_q.push_back(line_q[i]);
                        m_drain = 1'b1;
                        m_trunc = 1'b0;
                        m_age   = 0;
                    end
                    line_q.delete();
                    m_match = 0;
                end else if (line_q.size() == DEPTH) begin
                    out_q   = line_q;
                    line_q.delete();
                    m_drain = 1'b1;
                    m_trunc = 1'b1;
                    m_age   = 0;
                    m_match = 0;
                end
            end else if (stb) begin
                m_err   = (m_err == 255) ? 255 : m_err + 1;
                m_match = 0;
            end
        end
    end

    // Compare: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                bit exp_valid;
                exp_valid = m_drain && (m_age >= 1);
                chk("busy", busy, m_drain);
                chk("valid", bus.valid, exp_valid);
                chk("drop_cnt", drop_cnt, m_drop);
                chk("err_cnt", err_cnt, m_err);
                if (exp_valid) begin
                    chk("data", bus.data, out_q[0]);
                    chk("last", bus.last, (out_q.size() == 1));
                    chk("trunc", bus.trunc, m_trunc);
                end
                if (bus.valid === 1'b1 && rdy) log_q.push_back({bus.trunc, bus.last, bus.data});
                if (busy === 1'b1) busy_seen = 1'b1;
                if (bus.valid === 1'b1 && prev_valid !== 1'b1) first_valid_cyc = cyc;
                prev_valid = bus.valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] e);
        stb = 1'b1;
        din = b;
        {brk, perr, ferr} = e;
        last_stb_cyc = cyc;
        tick();
        stb = 1'b0;
        {brk, perr, ferr} = 3'b000;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 3'b000);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (m_drain && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_idle"}, (n < 400), 1'b1);
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [2:0] e;
        int s_cyc;
        int n;

        rst = 1'b1; stb = 1'b0; din = 8'h00; brk = 1'b0; perr = 1'b0; ferr = 1'b0; rdy = 1'b1;
        tick(); tick(); tick();
        cmp_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_last", bus.last, 1'b0);
        chk("rst_trunc", bus.trunc, 1'b0);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_err", err_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // "AB111"
        log_q.delete();
        send_str("AB111");
        s_cyc = last_stb_cyc;
        wait_idle("ab");
        chk("ab_n", log_q.size(), 2);
        chk("ab_0", log_q[0], 10'h041);
        chk("ab_1", log_q[1], 10'h142);
        chk("ab_latency", first_valid_cyc - s_cyc, 2);

        // partial terminator treated as payload
        log_q.delete();
        send_str("1A111");
        wait_idle("part");
        chk("part_n", log_q.size(), 2);
        chk("part_0", log_q[0], 10'h031);
        chk("part_1", log_q[1], 10'h141);

        // empty line then "Z111"
        log_q.delete();
        busy_seen = 1'b0;
        send_str("111");
        repeat (4) tick();
        chk("empty_busy", busy_seen, 1'b0);
        chk("empty_n", log_q.size(), 0);
        send_str("Z111");
        wait_idle("z");
        chk("z_n", log_q.size(), 1);
        chk("z_0", log_q[0], 10'h15A);

        // errored strobe in the line, drops while stalled
        log_q.delete();
        rdy = 1'b0;
        send(8'h41, 3'b000);
        send(8'h58, 3'b010);
        send_str("111");
        send(8'h10, 3'b000);
        tick();
        send(8'h11, 3'b100);
        send(8'h12, 3'b000);
        repeat (3) tick();
        chk("hold_valid", bus.valid, 1'b1);
        chk("hold_data", bus.data, 8'h41);
        chk("err_lit", err_cnt, 8'd1);
        chk("drop_lit", drop_cnt, 16'd3);
        rdy = 1'b1;
        wait_idle("err");
        chk("err_n", log_q.size(), 1);
        chk("err_0", log_q[0], 10'h141);

        // overflow: 16 bytes without terminator
        log_q.delete();
        for (int i = 0; i < DEPTH; i++) send(8'h55, 3'b000);
        wait_idle("ovf");
        chk("ovf_n", log_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("ovf_byte", log_q[i], (i == DEPTH - 1) ? 10'h355 : 10'h255);

        // reset after two of five bytes drained
        log_q.delete();
        send_str("ABCDE111");
        n = 0;
        while (log_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_wait", (n < 100), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus.valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        chk("mid_rst_err", err_cnt, 8'd0);
        tick();
        log_q.delete();
        send_str("C111");
        wait_idle("c");
        chk("c_n", log_q.size(), 1);
        chk("c_0", log_q[0], 10'h143);

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0, 1:    b = 8'h31;
                    2:       b = 8'h41;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                e = ($urandom_range(0, 9) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
                send(b, e);
            end else begin
                tick();
            end
        end
        rdy = 1'b1;
        wait_idle("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_line_framer.md
# rx_line_framer

Line-assembly stage between the UART receiver and the byte encrypter. It collects received bytes into a line buffer until the end-of-line sequence arrives: TERM_LEN consecutive TERM_BYTE bytes, default "111". It then streams the completed line out over a valid/ready interface. The downstream consumer is the encrypter/transmit path. While a line is draining, new input is dropped and counted rather than overwriting the buffer.

## Interface
- DEPTH_LG, 10: the buffer holds 2^DEPTH_LG bytes.
- TERM_BYTE, 8'h31: terminator byte value.
- TERM_LEN, 3: number of consecutive TERM_BYTEs that end a line (1..7).

- i_clk  in  1  system clock. One clock domain only.
- i_reset  in  1  synchronous, active-high reset.
- i_stb  in  1  one-cycle strobe: i_data is valid.
- i_data  in  8  received byte.
- i_break, i_perr, i_ferr  in  1 each  receiver error flags, sampled when i_stb=1.
- o_valid  out  1  output byte available.
- o_data  out  8  output byte.
- o_last  out  1  marks the final byte of the line.
- o_trunc  out  1  the line was closed because the buffer filled; valid while o_valid=1.
- i_ready  in  1  downstream accepts the byte.
- o_busy  out  1  block is in the DRAIN state.
- o_drop_cnt  out  16  saturating count of bytes discarded while in DRAIN.
- o_err_cnt  out  8  saturating count of strobes discarded because an error flag was set.

## Operation
- States:
  - FILL: accept input.
  - DRAIN: emit the line.
- FILL, good byte (i_stb=1 and all error flags 0):
  - Write the byte to mem[wr_ptr] and increment wr_ptr.
  - If i_data==TERM_BYTE, increment match; otherwise clear match.
- FILL, errored byte (i_stb=1 and any error flag 1):
  - Do not write; increment o_err_cnt (saturates at 255).
  - Clear match.
- Line complete: the good byte makes match==TERM_LEN.
  - line_len = wr_ptr+1-TERM_LEN. Terminator bytes are stored but not emitted.
  - If line_len==0, discard the line: clear wr_ptr and match, stay in FILL, emit nothing.
  - Otherwise go to DRAIN with o_trunc=0.
- Buffer full: a good byte is written to the last slot (wr_ptr==2^DEPTH_LG-1) and does not complete a terminator.
  - line_len = 2^DEPTH_LG.
  - Partial terminator bytes count as payload.
  - Go to DRAIN with o_trunc=1.
- Width rules:
  - wr_ptr, rd_ptr and line_len are DEPTH_LG+1 bits wide.
  - match is 3 bits wide.
- DRAIN:
  - Present mem[0] to mem[line_len-1] in order.
  - A byte transfers in any cycle where o_valid & i_ready.
  - o_last=1 exactly on byte line_len-1.
- Any i_stb during DRAIN, errored or not:
  - Increment o_drop_cnt (saturates at 65535).
  - Memory is not written.
- After the o_last transfer: return to FILL and clear wr_ptr, rd_ptr, match and o_trunc.
- Reset clears: state=FILL, wr_ptr, rd_ptr, match, o_valid, o_last, o_trunc, o_busy, o_data=0, o_drop_cnt, o_err_cnt. Memory contents are not cleared.

## Timing
- Memory is a single write port plus one registered read port, so read latency is 1 cycle.
- The completing byte strobes in cycle N:
  - o_busy=1 from N+1.
  - o_valid=1 with the first byte from N+2.
- o_data, o_last and o_trunc stay stable while o_valid & !i_ready.
- With i_ready held high, the output sustains one byte per cycle with no bubbles. The read pointer prefetches.
- After the o_last transfer in cycle M:
  - o_valid=0 and o_busy=0 from M+1.
  - An i_stb in cycle M is still counted as a drop.
  - An i_stb in M+1 is written to mem[0].
- i_reset asserted mid-DRAIN: o_valid=0 in the next cycle and the line is abandoned.
- i_reset has priority over every event in the same cycle.
- The counters update one cycle after the causing strobe.

## Test plan
- Line output:
  - Stimulus: feed "AB111" (41 42 31 31 31) with i_ready=1.
  - Response: exactly 2 transfers, 41 then 42 with o_last; o_valid rises 2 cycles after the last 31; o_busy falls after the 42 transfer.
- Partial terminator:
  - Stimulus: "1A11" then "1", i.e. 31 41 31 31 31.
  - Response: output is 31 41 with o_last; the first 31 is treated as payload.
- Empty line:
  - Stimulus: "111" alone.
  - Response: no o_valid and o_busy stays 0; a following "Z111" outputs only 5A.
- Errors and drops:
  - Stimulus: a strobe with i_perr=1 between "A" and "111"; then, during DRAIN, 3 strobes while i_ready=0.
  - Response: o_err_cnt=1 and the output is A only; o_drop_cnt=3; o_data stays held until i_ready rises.
- Overflow:
  - Stimulus: DEPTH_LG=4, feed 16 bytes of 0x55.
  - Response: 16 output bytes with o_trunc=1 and o_last on the 16th.
- Reset mid-operation:
  - Stimulus: assert i_reset after 2 of 5 bytes have drained.
  - Response: o_valid=0 next cycle, counters are 0, and the next "C111" outputs 43 only.
